// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: holds dmem requests until dhit, stalls upstream,
// owns the LL/SC link register and a saturating stall-cycle counter.
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic              datomic_i,
    input  logic              halt_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    input  logic              snoop_inv_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              datomic,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int WA_W = ADDR_W - 2;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              atom_q, atom_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              link_valid_q, link_valid_d;
    logic [WA_W-1:0]   link_addr_q, link_addr_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              req;
    logic              snoop_hit;
    logic              link_live;
    logic              sc_fail;
    logic              done;
    logic              stall;
    logic [DATA_W-1:0] result;
    logic              unused_ok;

    assign unused_ok = ^snoop_addr_i[1:0];

    assign req       = (dREN_i | dWEN_i) & ~halted_q;
    assign snoop_hit = snoop_inv_i & link_valid_q
                     & (snoop_addr_i[ADDR_W-1:2] == link_addr_q);
    // A snoop in the same cycle as an IDLE SC kills the link first.
    assign link_live = link_valid_q & ~snoop_hit;
    assign sc_fail   = dWEN_i & datomic_i
                     & (~link_live | (link_addr_q != addr_i[ADDR_W-1:2]));

    always_comb begin
        state_d      = state_q;
        ren_d        = ren_q;
        wen_d        = wen_q;
        atom_d       = atom_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        halted_d     = halted_q;
        cnt_d        = cnt_q;
        done         = 1'b0;
        stall        = 1'b0;
        result       = rdata_q;

        if (snoop_hit) begin
            link_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (sc_fail) begin
                        done   = 1'b1;
                        result = '0;
                    end else begin
                        ren_d   = dREN_i;
                        wen_d   = dWEN_i;
                        atom_d  = datomic_i;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        stall   = 1'b1;
                        state_d = BUSY;
                    end
                end else if (halt_i) begin
                    halted_d = 1'b1;
                end
            end
            BUSY: begin
                if (dhit) begin
                    done = 1'b1;
                    if (ren_q) begin
                        result = dmemload;
                    end else if (atom_q) begin
                        result = {{(DATA_W-1){1'b0}}, 1'b1};
                    end
                    // LL after snoop in the same cycle: the LL wins.
                    if (ren_q & atom_q) begin
                        link_addr_d  = addr_q[ADDR_W-1:2];
                        link_valid_d = 1'b1;
                    end else if (wen_q & atom_q) begin
                        link_valid_d = 1'b0;
                    end else if (wen_q
                                 & (addr_q[ADDR_W-1:2] == link_addr_q)) begin
                        link_valid_d = 1'b0;
                    end
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    atom_d  = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign rdata_d = result;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            atom_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            halted_q     <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            atom_q       <= atom_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            halted_q     <= halted_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    assign dmemREN     = ren_q;
    assign dmemWEN     = wen_q;
    assign datomic     = atom_q;
    assign dmemaddr    = addr_q;
    assign dmemstore   = wdata_q;
    assign mem_stall_o = stall;
    assign done_o      = done;
    assign rdata_o     = result;
    assign halted_o    = halted_q;
    assign stall_cnt_o = cnt_q;

endmodule
